mdu_seq: RTL and testbench

Multi-cycle unsigned multiply/divide sequencer for the processor datapath. It reuses one 32-bit ALU instance (`Alu32`) iteratively: 32 shift-add steps for MULU, and 32 shift-subtract restoring steps for DIVU. It sits beside the main ALU in the execute stage and stalls the pipeline on `busy`. The block has a single hi/lo result register pair, which holds each result until the next accepted start.

---
 rtl/mdu_pkg.sv | 13 +
 rtl/mdu_seq_alu32.sv | 19 +
 rtl/mdu_seq.sv | 68 ++++++
 tb/tb_mdu_seq.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared ALU control codes, operation codes and sequencer state encoding
package mdu_pkg;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic       OP_MULU = 1'b0;
    localparam logic       OP_DIVU = 1'b1;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
endpackage

// File: rtl/mdu_seq_alu32.sv
// Alu32: combinational 32-bit ALU; ctrl[3] inverts a, ctrl[2] negates b, ctrl[1:0] picks and/or/add/slt
// ports: ctrl (4), a, b (32) in; result (32), zero out
module Alu32 (
    input  logic [3:0]  ctrl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        zero
);
    logic [31:0] x, y, sum;
    assign x   = ctrl[3] ? ~a : a;
    assign y   = ctrl[2] ? ~b : b;
    assign sum = x + y + {31'b0, ctrl[2]};
    always_comb
        result = ctrl[1:0] == 2'b00 ? (x & y) :
                 ctrl[1:0] == 2'b01 ? (x | y) :
                 ctrl[1:0] == 2'b10 ? sum : {31'b0, sum[31]};
    assign zero = result == 32'b0;
endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: iterative unsigned 32-bit multiply/divide sequencer built around one Alu32
// ports: clk, rst_n (sync, active low), start, op (0 MULU, 1 DIVU), a, b in;
//        busy (state RUN), done (state DONE pulse), hi (product high / remainder), lo (product low / quotient) out
import mdu_pkg::*;
module mdu_seq #(
    parameter int XLEN  = 32,
    parameter int STEPS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    logic [1:0]      state;
    logic [XLEN-1:0] mc, sh, alu_a, alu_b, s;
    logic [4:0]      cnt;
    logic [3:0]      ctrl;
    logic            opr, x31, y31, cout, ge, zero_unused;
    assign busy  = state == S_RUN;
    assign done  = state == S_DONE;
    assign sh    = {hi[XLEN-2:0], lo[XLEN-1]};
    assign ctrl  = opr == OP_DIVU ? ALU_SUB : ALU_ADD;
    assign alu_a = opr == OP_DIVU ? sh : hi;
    assign alu_b = opr == OP_DIVU || lo[0] ? mc : '0;
    // carry out of the msb rebuilt from the post-inversion operand msbs and the sum msb
    assign x31   = ctrl[3] ^ alu_a[XLEN-1];
    assign y31   = ctrl[2] ^ alu_b[XLEN-1];
    assign cout  = (x31 & y31) | ((x31 | y31) & ~s[XLEN-1]);
    // hi[31] set means the shifted remainder already exceeds 32 bits, so it always fits the divisor
    assign ge    = hi[XLEN-1] | cout;
    Alu32 u_alu (
        .ctrl   (ctrl),
        .a      (alu_a),
        .b      (alu_b),
        .result (s),
        .zero   (zero_unused)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            hi    <= '0;
            lo    <= '0;
            mc    <= '0;
            cnt   <= '0;
            opr   <= OP_MULU;
        end else if (start && state != S_RUN) begin
            hi    <= '0;
            lo    <= op == OP_DIVU ? a : b;
            mc    <= op == OP_DIVU ? b : a;
            cnt   <= '0;
            opr   <= op;
            state <= S_RUN;
        end else if (state == S_RUN) begin
            hi    <= opr == OP_DIVU ? (ge ? s : sh) : {cout, s[XLEN-1:1]};
            lo    <= opr == OP_DIVU ? {lo[XLEN-2:0], ge} : {s[0], lo[XLEN-1:1]};
            cnt   <= cnt + 5'd1;
            state <= cnt == 5'(STEPS - 1) ? S_DONE : S_RUN;
        end else if (state == S_DONE) begin
            state <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: scoreboard bench for mdu_seq covering reset, mulu, divu, divide by zero and control corner cases
module tb_mdu_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;
    logic [63:0] sb[$];
    int          checks = 0;
    int          errors = 0;

    mdu_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        if (o == 1'b0) begin
            p = {32'b0, x} * {32'b0, y};
            return p;
        end
        if (y == 32'b0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
    endfunction

    task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y, input logic [63:0] exp);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // called in cycle n0 after the accepting edge; leaves the bench in the done cycle
    task automatic wait_result(input string name, input int n0);
        int n = n0;
        int busy_bad = 0;
        logic [63:0] exp;
        while (!done && n < 40) begin
            if (busy !== 1'b1) busy_bad++;
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 33 || busy_bad != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s latency got %0d want 33, busy low cycles %0d want 0, busy at done %b want 0", name, n, busy_bad, busy);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            exp = sb.pop_front();
            if ({hi, lo} !== exp) begin
                errors++;
                $display("FAIL %s result got hi=%h lo=%h want hi=%h lo=%h", name, hi, lo, exp[63:32], exp[31:0]);
            end
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'b0 || lo !== 32'b0) begin
            errors++;
            $display("FAIL %s got busy=%b done=%b hi=%h lo=%h want all zero", name, busy, done, hi, lo);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b1;
        op = 1'b0;
        a = 32'h5;
        b = 32'h7;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_idle("reset_hold");
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_idle("reset_release");
    endtask

    task automatic test_mulu;
        issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
        wait_result("mulu_max", 1);
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'hFFFFFFFE || lo !== 32'h1) begin
            errors++;
            $display("FAIL mulu_hold got done=%b busy=%b hi=%h lo=%h want 0 0 fffffffe 00000001", done, busy, hi, lo);
        end
    endtask

    task automatic test_divu;
        issue(1'b1, 32'd100, 32'd7, {32'd2, 32'd14});
        wait_result("divu_100_7", 1);
        issue(1'b1, 32'h80000000, 32'd3, {32'd2, 32'h2AAAAAAA});
        wait_result("divu_msb", 1);
    endtask

    task automatic test_div_zero;
        issue(1'b1, 32'h12345678, 32'd0, {32'h12345678, 32'hFFFFFFFF});
        wait_result("divu_zero", 1);
    endtask

    task automatic test_start_ignored;
        issue(1'b0, 32'd123456, 32'd789, model(1'b0, 32'd123456, 32'd789));
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        op = 1'b1;
        a = 32'hDEADBEEF;
        b = 32'h3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_result("start_in_run", 11);
    endtask

    task automatic test_back_to_back;
        issue(1'b1, 32'd1000, 32'd33, {32'd10, 32'd30});
        wait_result("b2b_first", 1);
        issue(1'b0, 32'h0001_0003, 32'h0002_0005, model(1'b0, 32'h0001_0003, 32'h0002_0005));
        wait_result("b2b_second", 1);
    endtask

    task automatic test_random;
        logic o;
        logic [31:0] x, y;
        for (int i = 0; i < 6; i++) begin
            o = 1'($urandom_range(0, 1));
            x = $urandom;
            y = (i == 5) ? 32'hFFFFFFFF : $urandom >> $urandom_range(0, 28);
            issue(o, x, y, model(o, x, y));
            wait_result(o ? "rand_divu" : "rand_mulu", 1);
        end
    endtask

    task automatic test_reset_mid_run;
        issue(1'b0, 32'hABCDEF01, 32'h12345678, 64'b0);
        void'(sb.pop_back());
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_idle("reset_mid_run");
        @(posedge clk);
        #1;
        check_idle("reset_mid_run_stays_idle");
        issue(1'b0, 32'h10000, 32'h10000, {32'd1, 32'd0});
        wait_result("mulu_after_reset", 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mulu();
        test_divu();
        test_div_zero();
        test_start_ignored();
        test_back_to_back();
        test_random();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
